// File: rtl/svc_uart_pkg.sv
// Shared UART definitions: line-decoder state encoding and baud helper,
// common to the receiver and the transmitter in the I/O register bank.
package svc_uart_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_IDLE,
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_e;

    // Whole clock cycles per bit period (rounded down).
    function automatic int unsigned clks_per_bit(input int unsigned freq,
                                                 input int unsigned baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/svc_sync2.sv
// Two-flop synchroniser for a single asynchronous level.
// The reset value lets an idle-high line look idle straight out of reset.
module svc_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Shift the raw input through two flops to settle metastability.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/svc_uart_rx.sv
// 8N1 UART receiver: synchronises the rx pin, qualifies the start bit,
// samples each bit mid-period and hands bytes out on a valid/ready stream.
// Framing errors and dropped bytes are reported as one-cycle pulses.
module svc_uart_rx
    import svc_uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 100_000_000,
    parameter int unsigned BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic       urx_valid,
    output logic [7:0] urx_data,
    input  logic       urx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int          CNT_W        = $clog2(CLKS_PER_BIT + 1);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Below four clocks per bit there is no usable mid-bit sample point.
    if (CLKS_PER_BIT < 4) begin : g_baud_check
        $error("svc_uart_rx: CLOCK_FREQ/BAUD_RATE must be at least 4");
    end

    logic             rx_s;
    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             valid_q, valid_d;
    logic [7:0]       data_q, data_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
    logic             offer;
    logic             load;

    svc_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (uart_rx),
        .q_o (rx_s)
    );

    // Register the decoder state, bit timing and holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_WAIT_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    // Decode the line: cnt_q counts cycles since the last sample point
    // (or consecutive idle-high cycles while waiting for a quiet line).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        offer   = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            ST_WAIT_IDLE: begin
                if (!rx_s) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_IDLE: begin
                if (!rx_s) begin
                    cnt_d   = CNT_ONE;
                    bit_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = CNT_ONE;
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = CNT_ONE;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        offer   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_WAIT_IDLE;
            end
        endcase
    end

    // Holding register: a finished byte loads if the slot is empty or is
    // being drained in the same cycle; otherwise it is dropped.
    always_comb begin
        load    = offer && (!valid_q || urx_ready);
        ovr_d   = offer && !load;
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = shift_q;
        end else if (valid_q && urx_ready) begin
            valid_d = 1'b0;
        end
    end

    assign urx_valid = valid_q;
    assign urx_data  = data_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign busy      = (state_q != ST_IDLE) && (state_q != ST_WAIT_IDLE);

endmodule

// File: tb/tb_svc_uart_rx.sv
// Bench for svc_uart_rx: frames are driven bit by bit, and a per-byte
// outcome model predicts the stream/pulse outputs every cycle.
module tb_svc_uart_rx;

    localparam int LAT = 98; // pin edge to urx_valid for 10 clocks per bit

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_rx;
    logic       urx_ready;
    logic       urx_valid;
    logic [7:0] urx_data;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit dc      = 1'b0;
    bit run_cmp = 1'b0;

    // kind 0: good byte offered, kind 1: framing error
    typedef struct {
        int         at;
        int         kind;
        logic [7:0] d;
    } ev_t;
    ev_t evq[$];

    bit         m_valid = 1'b0;
    bit         m_ferr  = 1'b0;
    bit         m_ovr   = 1'b0;
    logic [7:0] m_data  = 8'h00;

    always #5 clk = ~clk;

    svc_uart_rx #(
        .CLOCK_FREQ(1_000_000),
        .BAUD_RATE (100_000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .uart_rx  (uart_rx),
        .urx_valid(urx_valid),
        .urx_data (urx_data),
        .urx_ready(urx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Outcome model: what each frame does to the holding register.
    task automatic model_step();
        bit  hs;
        ev_t e;
        cyc++;
        if (rst) begin
            m_valid = 1'b0;
            m_data  = 8'h00;
            m_ferr  = 1'b0;
            m_ovr   = 1'b0;
            evq.delete();
        end else begin
            hs     = m_valid && urx_ready;
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
            if (evq.size() > 0 && evq[0].at == cyc) begin
                e = evq.pop_front();
                if (e.kind == 1) begin
                    m_ferr = 1'b1;
                    if (hs) m_valid = 1'b0;
                end else if (!m_valid || urx_ready) begin
                    m_valid = 1'b1;
                    m_data  = e.d;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (hs) begin
                m_valid = 1'b0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Compare DUT outputs against the model on the falling edge.
    initial forever begin
        @(negedge clk);
        if (run_cmp && !dc) begin
            chk("cyc_valid", urx_valid, m_valid);
            chk("cyc_frame_err", frame_err, m_ferr);
            chk("cyc_overrun", overrun, m_ovr);
            if (m_valid) chk("cyc_data", urx_data, m_data);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one 8N1 frame; kind 2 means the model expects nothing.
    task automatic send_byte(input logic [7:0] d, input logic stop, input int kind);
        ev_t e;
        if (kind != 2) begin
            e.at   = cyc + LAT;
            e.kind = kind;
            e.d    = d;
            evq.push_back(e);
        end
        uart_rx = 1'b0;
        tick(10);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            tick(10);
        end
        uart_rx = stop;
        tick(10);
    endtask

    task automatic send_expect(input logic [7:0] d, input string tag);
        fork
            send_byte(d, 1'b1, 0);
            begin
                tick(LAT);
                chk({tag, "_valid"}, urx_valid, 1);
                chk({tag, "_data"}, urx_data, d);
            end
        join
    endtask

    initial begin
        rst       = 1'b1;
        uart_rx   = 1'b1;
        urx_ready = 1'b0;
        tick(3);
        run_cmp = 1'b1;
        chk("rst_valid", urx_valid, 0);
        chk("rst_data", urx_data, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        tick(12);

        // 1: 0xA5 held with ready low, latency pinned, drained by one ready pulse
        fork
            send_byte(8'hA5, 1'b1, 0);
            begin
                tick(50);
                chk("t1_busy_mid", busy, 1);
                tick(LAT - 51);
                chk("t1_valid_early", urx_valid, 0);
                tick(1);
                chk("t1_valid", urx_valid, 1);
                chk("t1_data", urx_data, 8'hA5);
            end
        join
        tick(20);
        chk("t1_hold_valid", urx_valid, 1);
        chk("t1_hold_data", urx_data, 8'hA5);
        chk("t1_busy_idle", busy, 0);
        urx_ready = 1'b1;
        tick(1);
        urx_ready = 1'b0;
        chk("t1_drained", urx_valid, 0);
        tick(5);

        // 2: back-to-back 0x00, 0xFF with ready high
        urx_ready = 1'b1;
        fork
            begin
                send_byte(8'h00, 1'b1, 0);
                send_byte(8'hFF, 1'b1, 0);
            end
            begin
                tick(LAT);
                chk("t2_v0", urx_valid, 1);
                chk("t2_d0", urx_data, 8'h00);
                tick(1);
                chk("t2_pulse0", urx_valid, 0);
                tick(99);
                chk("t2_v1", urx_valid, 1);
                chk("t2_d1", urx_data, 8'hFF);
            end
        join
        tick(20);

        // 3: 3-cycle glitch rejected, then 0x3C
        uart_rx = 1'b0;
        tick(3);
        uart_rx = 1'b1;
        tick(15);
        chk("t3_glitch_busy", busy, 0);
        send_expect(8'h3C, "t3");
        tick(10);

        // 4: framing error, held-low line, early 0x81 ignored, later 0x81 received
        fork
            send_byte(8'h55, 1'b0, 1);
            begin
                tick(LAT);
                chk("t4_ferr", frame_err, 1);
                chk("t4_no_valid", urx_valid, 0);
                tick(1);
                chk("t4_ferr_pulse", frame_err, 0);
            end
        join
        tick(30);
        uart_rx = 1'b1;
        tick(5);
        dc = 1'b1;
        send_byte(8'h81, 1'b1, 2);
        tick(40);
        dc = 1'b0;
        send_expect(8'h81, "t4");
        tick(10);

        // 5: overrun with ready low, then a drain coinciding with 0x33's stop sample
        urx_ready = 1'b0;
        tick(5);
        send_expect(8'h11, "t5a");
        fork
            send_byte(8'h22, 1'b1, 0);
            begin
                tick(LAT);
                chk("t5_overrun", overrun, 1);
                chk("t5_keep_data", urx_data, 8'h11);
                chk("t5_keep_valid", urx_valid, 1);
                tick(1);
                chk("t5_overrun_pulse", overrun, 0);
            end
        join
        fork
            send_byte(8'h33, 1'b1, 0);
            begin
                tick(LAT - 1);
                urx_ready = 1'b1;
                tick(1);
                urx_ready = 1'b0;
                chk("t5_no_overrun", overrun, 0);
                chk("t5_valid33", urx_valid, 1);
                chk("t5_data33", urx_data, 8'h33);
            end
        join
        tick(5);
        urx_ready = 1'b1;
        tick(1);
        chk("t5_drained", urx_valid, 0);
        tick(5);

        // 6: reset mid-frame with the line low, then 0x7E after a quiet line
        uart_rx = 1'b0;
        tick(10);
        uart_rx = 1'b1;
        tick(40);
        uart_rx = 1'b0;
        tick(5);
        rst = 1'b1;
        tick(3);
        chk("t6_rst_valid", urx_valid, 0);
        chk("t6_rst_data", urx_data, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_frame_err", frame_err, 0);
        rst = 1'b0;
        tick(20);
        chk("t6_low_busy", busy, 0);
        uart_rx = 1'b1;
        tick(10);
        send_expect(8'h7E, "t6");
        tick(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
